// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding and defaults for the SRAM array controller.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACTIVE,
        RECOVER
    } sram_ctrl_state_t;

    localparam int WL_HOLD_DEF = 1;

endpackage

// File: rtl/sram_wl_decoder.sv
// sram_wl_decoder: one-hot row select; all-zero when disabled or address out of range.
module sram_wl_decoder #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [DEPTH-1:0]  wl
);

    always_comb begin
        wl = '0;
        for (int i = 0; i < DEPTH; i++)
            wl[i] = en && (32'(addr) == i);
    end

endmodule

// File: rtl/sram_array_ctrl.sv
// sram_array_ctrl: sequences bit-line setup, word-line pulse, sense and recovery
// for a DEPTH x WIDTH 6T SRAM array behind a single-request valid/ready port.
module sram_array_ctrl
    import sram_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int WL_HOLD = WL_HOLD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic [DEPTH-1:0]  wl,
    output logic [WIDTH-1:0]  bl1_drv,
    output logic [WIDTH-1:0]  bl2_drv,
    input  logic [WIDTH-1:0]  bl1_sense
);

    localparam int CNT_W = $clog2(WL_HOLD + 1);

    sram_ctrl_state_t  r_state;
    sram_ctrl_state_t  w_next;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_wdata;
    logic [WIDTH-1:0]  r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_accept;
    logic              w_last;
    logic              w_drv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_accept = req_valid;
                w_next   = req_valid ? SETUP : IDLE;
            end
            SETUP:   w_next = ACTIVE;
            ACTIVE: begin
                w_last = (r_cnt == '0);
                w_next = w_last ? RECOVER : ACTIVE;
            end
            RECOVER: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_err   <= {1'b0, req_addr} >= (ADDR_W + 1)'(DEPTH);
            end
            if (r_state == SETUP)
                r_cnt <= CNT_W'(WL_HOLD - 1);
            else if (r_state == ACTIVE && r_cnt != '0)
                r_cnt <= r_cnt - CNT_W'(1);
            if (w_last && !r_we)
                r_rdata <= r_err ? '0 : bl1_sense;
        end
    end

    sram_wl_decoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dec (
        .addr (r_addr),
        .en   (r_state == ACTIVE && !r_err),
        .wl   (wl)
    );

    // Write data is driven from SETUP through RECOVER so it brackets both word-line edges.
    assign w_drv     = r_we && (r_state != IDLE);
    assign bl1_drv   = w_drv ? r_wdata : 'z;
    assign bl2_drv   = w_drv ? ~r_wdata : 'z;
    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RECOVER);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// tb_sram_array_ctrl: directed checks of the SRAM controller with a behavioural cell array.
module tb_sram_array_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic        valid [3];
    logic        we    [3];
    logic [3:0]  addr  [3];
    logic [31:0] wdata [3];
    logic        ready [3];
    logic        rv    [3];
    logic        re    [3];
    logic [31:0] rdata [3];
    logic        rd_op [3];
    logic [15:0] wl0, wl1;
    logic [11:0] wl2;
    wire  [31:0] b1_0, b2_0, b1_1, b2_1, b1_2, b2_2;
    logic [31:0] s0, s1;
    logic [31:0] s2 = 32'hDEAD_BEEF;
    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];

    logic [31:0] g_bl1_setup, g_bl2_setup, g_bl1_rec;
    logic [15:0] g_wlseen;

    sram_array_ctrl u_dut (
        .clk(clk), .rst(rst), .req_valid(valid[0]), .req_ready(ready[0]), .req_we(we[0]),
        .req_addr(addr[0]), .req_wdata(wdata[0]), .rsp_valid(rv[0]), .rsp_rdata(rdata[0]),
        .rsp_err(re[0]), .wl(wl0), .bl1_drv(b1_0), .bl2_drv(b2_0), .bl1_sense(s0)
    );

    sram_array_ctrl #(.WL_HOLD(3)) u_h3 (
        .clk(clk), .rst(rst), .req_valid(valid[1]), .req_ready(ready[1]), .req_we(we[1]),
        .req_addr(addr[1]), .req_wdata(wdata[1]), .rsp_valid(rv[1]), .rsp_rdata(rdata[1]),
        .rsp_err(re[1]), .wl(wl1), .bl1_drv(b1_1), .bl2_drv(b2_1), .bl1_sense(s1)
    );

    sram_array_ctrl #(.DEPTH(12)) u_d12 (
        .clk(clk), .rst(rst), .req_valid(valid[2]), .req_ready(ready[2]), .req_we(we[2]),
        .req_addr(addr[2]), .req_wdata(wdata[2]), .rsp_valid(rv[2]), .rsp_rdata(rdata[2]),
        .rsp_err(re[2]), .wl(wl2), .bl1_drv(b1_2), .bl2_drv(b2_2), .bl1_sense(s2)
    );

    function automatic int idx(input logic [15:0] w);
        for (int i = 0; i < 16; i++)
            if (w[i]) return i;
        return 0;
    endfunction

    always_comb begin
        s0 = (wl0 != 0) ? mem0[idx(wl0)] : 32'hDEAD_BEEF;
        s1 = (wl1 != 0) ? mem1[idx(wl1)] : 32'hDEAD_BEEF;
    end

    // A cell only takes a write when the bit-line pair is genuinely complementary.
    always @(posedge clk) begin
        if (wl0 != 0 && b1_0 === ~b2_0) mem0[idx(wl0)] <= b1_0;
        if (wl1 != 0 && b1_1 === ~b2_1) mem1[idx(wl1)] <= b1_1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("wl0_onehot", 64'($onehot0(wl0)), 64'd1);
            chk("wl1_onehot", 64'($onehot0(wl1)), 64'd1);
            chk("wl2_onehot", 64'($onehot0(wl2)), 64'd1);
            if (rd_op[0]) begin
                chk("rd0_bl1_float", 64'(b1_0 === 32'bz), 64'd1);
                chk("rd0_bl2_float", 64'(b2_0 === 32'bz), 64'd1);
            end
            if (rd_op[1]) chk("rd1_bl1_float", 64'(b1_1 === 32'bz), 64'd1);
            if (rd_op[2]) chk("rd2_bl1_float", 64'(b1_2 === 32'bz), 64'd1);
        end
    end

    task automatic access(input int d, input logic w, input logic [3:0] a, input logic [31:0] dat,
                          output logic [31:0] rd, output logic er, output int lat, output int wlc);
        int n;
        logic [15:0] wv;
        valid[d] = 1'b1;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = dat;
        rd_op[d] = !w;
        n = 0;
        while (!ready[d] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1 valid[d] = 1'b0;
        lat = 0;
        wlc = 0;
        g_wlseen = '0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            wv = (d == 0) ? wl0 : (d == 1) ? wl1 : {4'b0, wl2};
            if (wv != 0) wlc++;
            g_wlseen |= wv;
            if (lat == 1) begin
                g_bl1_setup = b1_0;
                g_bl2_setup = b2_0;
            end
            if (rv[d]) break;
        end
        g_bl1_rec = b1_0;
        rd = rdata[d];
        er = re[d];
        @(posedge clk);
        #1 rd_op[d] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, wlc;
    logic        bw_we   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0]  bw_addr [4] = '{4'd7, 4'd8, 4'd7, 4'd8};
    logic [31:0] bw_dat  [4] = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0};
    logic [31:0] resp    [4];
    int          tacc    [4];

    initial begin
        int k, cyc, nresp, nlow;
        logic acc;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; rd_op[i] = 1'b0;
        end
        @(negedge clk);
        chk("rst_ready", 64'(ready[0]), 64'd1);
        chk("rst_rsp_valid", 64'(rv[0]), 64'd0);
        chk("rst_rdata", 64'(rdata[0]), 64'd0);
        chk("rst_err", 64'(re[0]), 64'd0);
        chk("rst_wl", 64'(wl0), 64'd0);
        chk("rst_bl1_float", 64'(b1_0 === 32'bz), 64'd1);
        chk("rst_bl2_float", 64'(b2_0 === 32'bz), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        access(0, 1'b1, 4'd3, 32'hA5A5_1234, rd, er, lat, wlc);
        chk("wr3_latency", 64'(lat), 64'd3);
        chk("wr3_wl_cycles", 64'(wlc), 64'd1);
        chk("wr3_wl_row", 64'(g_wlseen), 64'h0008);
        chk("wr3_err", 64'(er), 64'd0);
        chk("wr3_bl1_setup", 64'(g_bl1_setup), 64'hA5A5_1234);
        chk("wr3_bl2_setup", 64'(g_bl2_setup), 64'h5A5A_EDCB);
        chk("wr3_bl1_recover", 64'(g_bl1_rec), 64'hA5A5_1234);
        chk("wr3_bl_release", 64'(b1_0 === 32'bz), 64'd1);

        access(0, 1'b0, 4'd3, 32'h0, rd, er, lat, wlc);
        chk("rd3_latency", 64'(lat), 64'd3);
        chk("rd3_data", 64'(rd), 64'hA5A5_1234);
        chk("rd3_err", 64'(er), 64'd0);
        chk("rd3_wl_row", 64'(g_wlseen), 64'h0008);

        access(0, 1'b1, 4'd5, 32'hFFFF_FFFF, rd, er, lat, wlc);
        chk("wr5_rdata_hold", 64'(rd), 64'hA5A5_1234);
        access(0, 1'b0, 4'd5, 32'h0, rd, er, lat, wlc);
        chk("rd5_data", 64'(rd), 64'hFFFF_FFFF);
        access(0, 1'b0, 4'd5, 32'h0, rd, er, lat, wlc);
        chk("rd5_reread", 64'(rd), 64'hFFFF_FFFF);

        k = 0; cyc = 0; nresp = 0; nlow = 0;
        valid[0] = 1'b1; we[0] = bw_we[0]; addr[0] = bw_addr[0]; wdata[0] = bw_dat[0];
        while (cyc < 60 && (k < 4 || nresp < 4)) begin
            @(negedge clk);
            cyc++;
            if (rv[0] && nresp < 4) begin
                resp[nresp] = rdata[0];
                nresp++;
            end
            acc = valid[0] && ready[0];
            if (k > 0 && k < 4 && !ready[0]) nlow++;
            if (acc) tacc[k] = cyc;
            @(posedge clk);
            #1;
            if (acc) begin
                rd_op[0] = !bw_we[k];
                k++;
                if (k < 4) begin
                    we[0] = bw_we[k]; addr[0] = bw_addr[k]; wdata[0] = bw_dat[k];
                end else
                    valid[0] = 1'b0;
            end
        end
        rd_op[0] = 1'b0;
        chk("b2b_accepted", 64'(k), 64'd4);
        chk("b2b_responses", 64'(nresp), 64'd4);
        chk("b2b_gap01", 64'(tacc[1] - tacc[0]), 64'd4);
        chk("b2b_gap12", 64'(tacc[2] - tacc[1]), 64'd4);
        chk("b2b_gap23", 64'(tacc[3] - tacc[2]), 64'd4);
        chk("b2b_ready_low", 64'(nlow), 64'd9);
        chk("b2b_rd7", 64'(resp[2]), 64'h1111_1111);
        chk("b2b_rd8", 64'(resp[3]), 64'h2222_2222);

        access(1, 1'b1, 4'd0, 32'hCAFE_F00D, rd, er, lat, wlc);
        chk("h3_wr_latency", 64'(lat), 64'd5);
        chk("h3_wr_wl_cycles", 64'(wlc), 64'd3);
        access(1, 1'b0, 4'd0, 32'h0, rd, er, lat, wlc);
        chk("h3_rd_latency", 64'(lat), 64'd5);
        chk("h3_rd_wl_cycles", 64'(wlc), 64'd3);
        chk("h3_rd_wl_row", 64'(g_wlseen), 64'h0001);
        chk("h3_rd_data", 64'(rd), 64'hCAFE_F00D);

        access(2, 1'b0, 4'd13, 32'h0, rd, er, lat, wlc);
        chk("d12_a13_latency", 64'(lat), 64'd3);
        chk("d12_a13_wl", 64'(wlc), 64'd0);
        chk("d12_a13_err", 64'(er), 64'd1);
        chk("d12_a13_data", 64'(rd), 64'd0);
        access(2, 1'b0, 4'd12, 32'h0, rd, er, lat, wlc);
        chk("d12_a12_err", 64'(er), 64'd1);
        chk("d12_a12_wl", 64'(wlc), 64'd0);
        access(2, 1'b0, 4'd11, 32'h0, rd, er, lat, wlc);
        chk("d12_a11_err", 64'(er), 64'd0);
        chk("d12_a11_wl_row", 64'(g_wlseen), 64'h0800);
        chk("d12_a11_data", 64'(rd), 64'hDEAD_BEEF);

        valid[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'd9; wdata[0] = 32'h1234_5678;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_wl_active", 64'(wl0), 64'h0200);
        rst = 1'b1;
        #1;
        chk("abort_wl_zero", 64'(wl0), 64'd0);
        chk("abort_bl1_float", 64'(b1_0 === 32'bz), 64'd1);
        chk("abort_bl2_float", 64'(b2_0 === 32'bz), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", 64'(rv[0]), 64'd0);
        end
        chk("abort_ready", 64'(ready[0]), 64'd1);
        access(0, 1'b0, 4'd3, 32'h0, rd, er, lat, wlc);
        chk("post_rst_rd3", 64'(rd), 64'hA5A5_1234);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
